// File: rtl/dac_ramp_gen.sv
// Prescaled code generator for an R2R DAC: sawtooth, triangle, slew-to-setpoint and hold.
// All outputs are registered; a prescaler tick advances the waveform by one step.
module dac_ramp_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] setpoint,
  input  logic             setpoint_valid,
  output logic [WIDTH-1:0] dac_out,
  output logic             at_target,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ModeSaw  = 2'b00,
    ModeTri  = 2'b01,
    ModeSlew = 2'b10,
    ModeHold = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  localparam logic [WIDTH:0] CodeMax = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] StepOne = {{WIDTH{1'b0}}, 1'b1};

  mode_e            mode_s;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] target_q, target_d;
  dir_e             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             at_target_q;

  // Arithmetic is carried one bit wider so carry and borrow are visible.
  logic [WIDTH:0]   s_ext, code_ext, tgt_ext, sum, diff, tgt_plus_s;

  assign mode_s = mode_e'(mode);

  // Prescaler: counts 0..div while enabled, held at zero otherwise.
  assign tick = enable && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  assign s_ext      = (step == '0) ? StepOne : {1'b0, step};
  assign code_ext   = {1'b0, code_q};
  assign tgt_ext    = {1'b0, target_q};
  assign sum        = code_ext + s_ext;
  assign diff       = code_ext - s_ext;
  assign tgt_plus_s = tgt_ext + s_ext;

  // A strobe on a tick edge is captured here but the tick below still sees target_q.
  assign target_d = setpoint_valid ? setpoint : target_q;

  always_comb begin
    code_d = code_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (tick) begin
      case (mode_s)
        ModeSaw: begin
          code_d = sum[WIDTH-1:0];
          wrap_d = sum[WIDTH];
        end
        ModeTri: begin
          if (dir_q == DirUp) begin
            if (sum >= CodeMax) begin
              code_d = CodeMax[WIDTH-1:0];
              dir_d  = DirDown;
              wrap_d = 1'b1;
            end else begin
              code_d = sum[WIDTH-1:0];
            end
          end else begin
            if (code_ext <= s_ext) begin
              code_d = '0;
              dir_d  = DirUp;
              wrap_d = 1'b1;
            end else begin
              code_d = diff[WIDTH-1:0];
            end
          end
        end
        ModeSlew: begin
          if (code_q < target_q) begin
            code_d = (sum >= tgt_ext) ? target_q : sum[WIDTH-1:0];
          end else if (code_q > target_q) begin
            code_d = (code_ext <= tgt_plus_s) ? target_q : diff[WIDTH-1:0];
          end
        end
        ModeHold: begin
        end
      endcase
    end
    // Leaving triangle mode always restarts the next triangle on an upward leg.
    if (mode_s != ModeTri) begin
      dir_d = DirUp;
    end
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      cnt_q       <= '0;
      code_q      <= '0;
      target_q    <= '0;
      dir_q       <= DirUp;
      wrap_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
      at_target_q <= (code_q == target_q);
    end
  end

  assign dac_out   = code_q;
  assign at_target = at_target_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dac_ramp_gen.sv
// Directed plus randomized bench for dac_ramp_gen against an integer reference model.
module tb_dac_ramp_gen;

  localparam int W       = 8;
  localparam int DW      = 16;
  localparam int MaxCode = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  step;
  logic [W-1:0]  setpoint;
  logic          setpoint_valid;
  logic [W-1:0]  dac_out;
  logic          at_target;
  logic          wrap;

  int vectors = 0;
  int errors  = 0;
  int n;

  // Reference model state
  int m_dac, m_tgt, m_cnt, m_wrap, m_at;
  bit m_up;

  int saw_exp[4] = '{64, 128, 192, 0};
  int tri_exp[7] = '{100, 200, 255, 155, 55, 0, 100};

  dac_ramp_gen #(
    .WIDTH(W),
    .DIV_W(DW)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .enable        (enable),
    .mode          (mode),
    .div           (div),
    .step          (step),
    .setpoint      (setpoint),
    .setpoint_valid(setpoint_valid),
    .dac_out       (dac_out),
    .at_target     (at_target),
    .wrap          (wrap)
  );

  always #50 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dac  = 0;
    m_tgt  = 0;
    m_cnt  = 0;
    m_up   = 1'b1;
    m_wrap = 0;
    m_at   = 1;
  endtask

  // One clock edge of the behavioural model, from the inputs present at that edge.
  task automatic model_step();
    int s, nd, nt, nc, nw, na;
    bit nu, tk;
    if (n_reset) begin
      model_reset();
      return;
    end
    s  = (step == 0) ? 1 : int'(step);
    tk = enable && (m_cnt == int'(div));
    nc = (!enable || tk) ? 0 : m_cnt + 1;
    nd = m_dac;
    nu = m_up;
    nw = 0;
    na = (m_dac == m_tgt) ? 1 : 0;
    nt = setpoint_valid ? int'(setpoint) : m_tgt;
    if (tk) begin
      case (mode)
        2'd0: begin
          nd = (m_dac + s) % (MaxCode + 1);
          nw = (m_dac + s > MaxCode) ? 1 : 0;
        end
        2'd1: begin
          if (m_up) begin
            if (m_dac + s >= MaxCode) begin
              nd = MaxCode; nu = 1'b0; nw = 1;
            end else begin
              nd = m_dac + s;
            end
          end else begin
            if (m_dac <= s) begin
              nd = 0; nu = 1'b1; nw = 1;
            end else begin
              nd = m_dac - s;
            end
          end
        end
        2'd2: begin
          if (m_dac < m_tgt) nd = (m_dac + s < m_tgt) ? m_dac + s : m_tgt;
          else if (m_dac > m_tgt) nd = (m_dac - s > m_tgt) ? m_dac - s : m_tgt;
        end
        default: begin
        end
      endcase
    end
    if (mode != 2'd1) nu = 1'b1;
    m_dac  = nd;
    m_tgt  = nt;
    m_cnt  = nc;
    m_up   = nu;
    m_wrap = nw;
    m_at   = na;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("dac_out", dac_out, m_dac);
    check("wrap", wrap, m_wrap);
    check("at_target", at_target, m_at);
  endtask

  task automatic wait_change(output int cycles);
    logic [W-1:0] prev;
    prev   = dac_out;
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (dac_out === prev && cycles < 40);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #20 n_reset = 1'b1;
    #5;
    model_reset();
    check("rst_dac", dac_out, 0);
    check("rst_at", at_target, 1);
    check("rst_wrap", wrap, 0);
    #10 n_reset = 1'b0;
  endtask

  initial begin
    n_reset = 1'b1; enable = 1'b0; mode = 2'd0; div = '0;
    step = '0; setpoint = '0; setpoint_valid = 1'b0;
    model_reset();
    #10;
    check("init_dac", dac_out, 0);
    check("init_at", at_target, 1);
    check("init_wrap", wrap, 0);

    // Strobe held through an edge during reset must not load the target
    setpoint = 8'd77; setpoint_valid = 1'b1;
    cyc();
    #20 n_reset = 1'b0; setpoint_valid = 1'b0;
    mode = 2'd2; div = '0; enable = 1'b1; step = 8'd10;
    repeat (3) cyc();
    check("rst_sv_ignored", dac_out, 0);

    // Sawtooth, div=0, step=64
    mode = 2'd0; step = 8'd64;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("saw_code", dac_out, saw_exp[i]);
      check("saw_wrap", wrap, (i == 3) ? 1 : 0);
    end

    // Triangle, step=100
    mode = 2'd1; step = 8'd100;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("tri_code", dac_out, tri_exp[i]);
      check("tri_wrap", wrap, (i == 2 || i == 5) ? 1 : 0);
    end

    // Reset mid-ramp, then asynchronous reset on the down-ramp at 155
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("tri2_code", dac_out, tri_exp[i]);
    end
    pulse_reset();
    cyc();
    check("restart_1", dac_out, 100);
    cyc();
    check("restart_2", dac_out, 200);

    // Slew, div=3, step=10, setpoint 25 then 5
    pulse_reset();
    mode = 2'd2; step = 8'd10; div = 16'd3; setpoint = 8'd25; setpoint_valid = 1'b1;
    cyc();
    setpoint_valid = 1'b0;
    wait_change(n);
    check("slew_n1", n, 3);
    check("slew_c1", dac_out, 10);
    wait_change(n);
    check("slew_n2", n, 4);
    check("slew_c2", dac_out, 20);
    wait_change(n);
    check("slew_n3", n, 4);
    check("slew_c3", dac_out, 25);
    check("slew_at_lag", at_target, 0);
    cyc();
    check("slew_at", at_target, 1);
    setpoint = 8'd5; setpoint_valid = 1'b1;
    cyc();
    setpoint_valid = 1'b0;
    wait_change(n);
    check("slew_n4", n, 2);
    check("slew_c4", dac_out, 15);
    wait_change(n);
    check("slew_n5", n, 4);
    check("slew_c5", dac_out, 5);

    // Tick coinciding with the strobe still uses the old target
    div = '0; setpoint = 8'd50; setpoint_valid = 1'b1;
    cyc();
    check("sv_same_tick", dac_out, 5);
    setpoint_valid = 1'b0;
    cyc();
    check("sv_next_tick", dac_out, 15);

    // Slew with step=0 behaves as step=1
    pulse_reset();
    step = '0; setpoint = 8'd3; setpoint_valid = 1'b1;
    cyc();
    check("step0_c0", dac_out, 0);
    setpoint_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("step0_code", dac_out, (i < 3) ? i : 3);
    end

    // Enable freeze with div=4
    mode = 2'd0; step = 8'd1; div = 16'd4; enable = 1'b0;
    cyc();
    enable = 1'b1;
    wait_change(n);
    check("en_n1", n, 5);
    check("en_c1", dac_out, 4);
    wait_change(n);
    check("en_n2", n, 5);
    repeat (2) cyc();
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("en_frozen", dac_out, 5);
    end
    enable = 1'b1;
    wait_change(n);
    check("en_resume_n", n, 5);
    check("en_resume_c", dac_out, 6);

    // Randomized traffic; div only changes while the prescaler is held at zero
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        enable = 1'b0;
        div    = 16'($urandom_range(0, 3));
      end else begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      step           = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      setpoint       = 8'($urandom);
      setpoint_valid = ($urandom_range(0, 7) == 0);
      n_reset        = ($urandom_range(0, 199) == 0);
      cyc();
    end
    n_reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dac_ramp_gen.md
DAC_RAMP_GEN -- requirements
Module: dac_ramp_gen

Interface
REQ-001 Parameter WIDTH, default 8, DAC code width (R2R resolution).
REQ-002 Parameter DIV_W, default 16, prescaler divider width.
REQ-003 clk  input  1  system clock, 10 MHz nominal.
REQ-004 n_reset  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  tick generation enable; low freezes all output state.
REQ-006 mode  input  2  00 sawtooth, 01 triangle, 10 slew-to-setpoint, 11 hold.
REQ-007 div  input  DIV_W  tick period minus one, in clk cycles.
REQ-008 step  input  WIDTH  code increment per tick; 0 treated as 1.
REQ-009 setpoint  input  WIDTH  target code for slew mode.
REQ-010 setpoint_valid  input  1  single-cycle strobe capturing setpoint.
REQ-011 dac_out  output  WIDTH  registered code to R2R DAC.
REQ-012 at_target  output  1  registered; high when dac_out equals captured target.
REQ-013 wrap  output  1  registered one-cycle pulse on sawtooth wrap or triangle turn.

Function
REQ-014 Prescaler SHALL count 0..div and assert internal tick on the cycle count equals div, then return to 0; div=0 gives a tick every cycle.
REQ-015 enable low SHALL hold the prescaler at 0, suppress ticks, and hold dac_out; the first tick after enable rises SHALL occur div+1 cycles later.
REQ-016 setpoint_valid SHALL load target register on the same edge, in any mode and regardless of enable.
REQ-017 A tick coinciding with setpoint_valid SHALL use the previous target; the new target applies from the next tick.
REQ-018 Effective step s = (step==0) ? 1 : step; all add/subtract SHALL be computed in WIDTH+1 bits.
REQ-019 Sawtooth, per tick: dac_out <= (dac_out + s) mod 2^WIDTH; wrap SHALL pulse on the tick where carry-out is 1.
REQ-020 Triangle, direction up: if dac_out + s >= 2^WIDTH-1 then dac_out <= 2^WIDTH-1, direction <= down, wrap pulses; else dac_out <= dac_out + s.
REQ-021 Triangle, direction down: if dac_out <= s then dac_out <= 0, direction <= up, wrap pulses; else dac_out <= dac_out - s.
REQ-022 Direction SHALL be forced to up on every cycle mode != 01.
REQ-023 Slew, per tick: dac_out < target gives min(dac_out + s, target); dac_out > target gives max(dac_out - s, target); equal holds; wrap never pulses.
REQ-024 Hold: dac_out SHALL not change; wrap never pulses.
REQ-025 Mode change SHALL take effect on the first tick sampled with the new mode; no output change between ticks.
REQ-026 at_target SHALL reflect dac_out == target as registered one cycle after either changes, in all modes.
REQ-027 wrap SHALL be low on every cycle other than the qualifying tick's following cycle.

Reset
REQ-028 n_reset high SHALL immediately force dac_out=0, target=0, prescaler=0, direction=up, wrap=0, at_target=1.
REQ-029 Reset mid-ramp SHALL abort the ramp; after release, output resumes from 0 with first tick div+1 cycles later.
REQ-030 setpoint_valid asserted during reset SHALL be ignored.

Verification (WIDTH=8)
REQ-031 Sawtooth, div=0, step=64, enable=1 -> dac_out 64,128,192,0 on successive cycles; wrap one pulse coincident with code 0.
REQ-032 Triangle, div=0, step=100 -> 100,200,255(wrap),155,55,0(wrap),100.
REQ-033 Slew, div=3, step=10, setpoint=25 from 0 -> dac_out 10,20,25 at 4-cycle intervals; at_target high one cycle after 25; then setpoint=5 -> 15,5.
REQ-034 div=4, enable toggled low for 7 cycles mid-ramp -> dac_out frozen; next change exactly 5 cycles after enable returns high.
REQ-035 Slew with step=0, setpoint=3 -> dac_out 1,2,3 then holds.
REQ-036 n_reset pulsed asynchronously (between edges) during triangle down-ramp at code 155 -> dac_out=0, at_target=1 without clock edge; restart climbs from 0.
